// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam logic [31:0] PC_INC           = 32'd4;

    // RUN: normal fetching. DRAIN: the cycle after a redirect, where a
    // response belonging to the old instruction stream may still arrive.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries with a single-cycle flush.
// The caller must not push when full unless it pops in the same cycle.
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  fetch_entry_t                   push_data_i,
    input  logic                           pop_i,
    output fetch_entry_t                   head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && !empty_o;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; flush wins over any push or pop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is written with <= so every register samples pre-edge values.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    // NOTE: the storage array has no reset; occupancy is reset and the output mux hides stale words.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers the
// returning instructions in order, and restarts the stream on redirect.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc4
);

    localparam int          CNT_W       = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             req_epoch_q, req_epoch_d;
    logic             epoch_q, epoch_d;
    logic             issue;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_data;
    logic             pop;
    logic             resp_accept;
    logic             push;
    logic [CNT_W:0]   slots_used;
    logic             unused_rpc_bits;

    // Target addresses are word aligned; the low bits are ignored.
    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign pop = !fifo_empty && out_ready;

    // A pop this cycle frees a slot, which keeps a full-rate stream at DEPTH=2.
    assign slots_used = {1'b0, fifo_count}
                      + (CNT_W+1)'(inflight_q)
                      - (CNT_W+1)'(pop);

    // Only responses from the current epoch are written, never during DRAIN.
    assign resp_accept = inflight_q && (req_epoch_q == epoch_q) && (state_q == ST_RUN);
    assign push        = resp_accept && (!fifo_full || pop);
    assign push_data   = '{pc: req_pc_q, instr: imem_rdata};

    // Fetch FSM, fetch PC and request issue.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        issue       = 1'b0;

        case (state_q)
            ST_RUN:   state_d = redirect ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            epoch_d = ~epoch_q;
        end else if (rst_n && (slots_used < (CNT_W+1)'(DEPTH))) begin
            issue = 1'b1;
            pc_d  = pc_q + PC_INC;
        end

        inflight_d  = issue;
        req_pc_d    = issue ? pc_q : req_pc_q;
        req_epoch_d = epoch_q;
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC_AL;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            req_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            req_epoch_q <= req_epoch_d;
            epoch_q     <= epoch_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Head presentation; outputs read zero whenever nothing is buffered.
    assign out_valid = !fifo_empty;
    assign out_instr = fifo_empty ? '0 : fifo_head.instr;
    assign out_pc    = fifo_empty ? '0 : fifo_head.pc;
    assign out_pc4   = fifo_empty ? '0 : fifo_head.pc + PC_INC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (RESET_PC=0, DEPTH=2).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instr_fetch_unit #(
        .RESET_PC (32'd0),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a recognisable function of the word index.
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h5A00_0000 ^ (a >> 2);
    endfunction

    // Memory model: a request seen in cycle N returns its word during cycle N+1.
    logic        mem_pend;
    logic [31:0] mem_addr;
    always @(negedge clk) begin
        mem_pend = imem_req;
        mem_addr = imem_addr;
    end
    always @(posedge clk) begin
        #1;
        imem_rdata = mem_pend ? word(mem_addr) : 32'hBAD0_0BAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Entered at posedge+1; leaves at posedge+1 with reset released (cycle 0).
    task automatic do_reset();
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_req",   32'(imem_req),  32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc",    out_pc,    32'd0);
        check("rst_pc4",   out_pc4,   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        out_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        bit          do_reset;
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_valid;
        logic [31:0] exp_pc;
        bit          exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input bit rst, input bit rdy, input bit rd,
                                input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                                input bit erq, input logic [31:0] ead);
        vec_t v;
        v.name = n;  v.do_reset = rst; v.ready = rdy; v.redir = rd; v.rpc = rpc;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_req = erq; v.exp_addr = ead;
        vecs.push_back(v);
    endfunction

    int          got;
    bit          seen_stale;

    initial begin
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rdata  = '0;

        // Streaming with out_ready=1: two-cycle latency, then one per cycle.
        add("stream_c0", 1, 1, 0, 0, 0, 0,  1, 0);
        add("stream_c1", 0, 1, 0, 0, 0, 0,  1, 4);
        add("stream_c2", 0, 1, 0, 0, 1, 0,  1, 8);
        add("stream_c3", 0, 1, 0, 0, 1, 4,  1, 12);
        add("stream_c4", 0, 1, 0, 0, 1, 8,  1, 16);
        add("stream_c5", 0, 1, 0, 0, 1, 12, 1, 20);
        // Backpressure: buffer fills to DEPTH, requests stop, head holds pc 0.
        add("stall_c0", 1, 0, 0, 0, 0, 0, 1, 0);
        add("stall_c1", 0, 0, 0, 0, 0, 0, 1, 4);
        for (int k = 2; k < 12; k++) add($sformatf("stall_c%0d", k), 0, 0, 0, 0, 1, 0, 0, 0);
        add("release_c0", 0, 1, 0, 0, 1, 0,  1, 8);
        add("release_c1", 0, 1, 0, 0, 1, 4,  1, 12);
        add("release_c2", 0, 1, 0, 0, 1, 8,  1, 16);
        add("release_c3", 0, 1, 0, 0, 1, 12, 1, 20);
        // Pop of pc 0 together with redirect to 0xB: pc 4 in flight is dropped, target aligns to 8.
        add("jal_c0", 1, 1, 0, 0,        0, 0,  1, 0);
        add("jal_c1", 0, 1, 0, 0,        0, 0,  1, 4);
        add("jal_c2", 0, 1, 1, 32'h0000_000B, 1, 0, 0, 0);
        add("jal_c3", 0, 1, 0, 0,        0, 0,  1, 8);
        add("jal_c4", 0, 1, 0, 0,        0, 0,  1, 12);
        add("jal_c5", 0, 1, 0, 0,        1, 8,  1, 16);
        add("jal_c6", 0, 1, 0, 0,        1, 12, 1, 20);
        // Redirect with an empty buffer and pc 0 in flight: that response is dropped.
        add("jr_c0", 1, 1, 0, 0,          0, 0,        1, 0);
        add("jr_c1", 0, 1, 1, 32'h40,     0, 0,        0, 0);
        add("jr_c2", 0, 1, 0, 0,          0, 0,        1, 32'h40);
        add("jr_c3", 0, 1, 0, 0,          0, 0,        1, 32'h44);
        add("jr_c4", 0, 1, 0, 0,          1, 32'h40,   1, 32'h48);
        add("jr_c5", 0, 1, 0, 0,          1, 32'h44,   1, 32'h4C);

        next_cycle();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) do_reset();
            step(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'(vecs[i].exp_valid));
            check({vecs[i].name, "_req"},   32'(imem_req),  32'(vecs[i].exp_req));
            if (vecs[i].exp_req) check({vecs[i].name, "_addr"}, imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                check({vecs[i].name, "_pc"},    out_pc,    vecs[i].exp_pc);
                check({vecs[i].name, "_pc4"},   out_pc4,   vecs[i].exp_pc + 32'd4);
                check({vecs[i].name, "_instr"}, out_instr, word(vecs[i].exp_pc));
            end
            next_cycle();
        end

        // Redirect to 12 while pcs 4 and 8 sit in the buffer.
        do_reset();
        step(0, 0, 0); next_cycle();
        step(0, 0, 0); next_cycle();
        step(1, 0, 0); check("r36_head0", out_pc, 32'd0); next_cycle();
        step(0, 0, 0); check("r36_head4", out_pc, 32'd4); next_cycle();
        step(0, 1, 32'd12);
        check("r36_redir_req",  32'(imem_req), 32'd0);
        check("r36_held_head",  out_pc, 32'd4);
        next_cycle();
        step(1, 0, 0);
        check("r36_flushed",    32'(out_valid), 32'd0);
        check("r36_target_req", 32'(imem_req),  32'd1);
        check("r36_target",     imem_addr, 32'd12);
        next_cycle();
        got        = 0;
        seen_stale = 1'b0;
        for (int k = 0; k < 20 && got < 3; k++) begin
            step(1, 0, 0);
            if (out_valid) begin
                if (out_pc == 32'd4 || out_pc == 32'd8) seen_stale = 1'b1;
                check($sformatf("r36_seq%0d", got), out_pc, 32'd12 + 32'(4 * got));
                got++;
            end
            next_cycle();
        end
        check("r36_count",    32'(got), 32'd3);
        check("r36_no_stale", 32'(seen_stale), 32'd0);

        // Half-cycle reset pulse mid-stream.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0);
            next_cycle();
        end
        step(1, 0, 0);
        check("r39_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r39_valid_drop", 32'(out_valid), 32'd0);
        check("r39_req_drop",   32'(imem_req),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0); check("r39_restart_addr", imem_addr, 32'd0); next_cycle();
        step(1, 0, 0); check("r39_c1_valid", 32'(out_valid), 32'd0); next_cycle();
        step(1, 0, 0); check("r39_c2_pc", out_pc, 32'd0); next_cycle();
        step(1, 0, 0); check("r39_c3_pc", out_pc, 32'd4); next_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: output buffer entries; legal values 2..8.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request valid this cycle.
REQ-006 imem_addr  output  32  byte address of the request; bits [1:0] are always 0.
REQ-007 imem_rdata  input  32  instruction word, valid exactly one cycle after its request.
REQ-008 redirect  input  1  control-flow change (J, JAL, JR, taken BEQ/BNE) from the downstream cores.
REQ-009 redirect_pc  input  32  target address of the redirect.
REQ-010 out_valid  output  1  out_instr/out_pc/out_pc4 hold a fetched instruction.
REQ-011 out_ready  input  1  the 4-core datapath accepts the head instruction.
REQ-012 out_instr  output  32  instruction word, shared by all cores.
REQ-013 out_pc  output  32  address of out_instr.
REQ-014 out_pc4  output  32  out_pc+4, modulo 2^32 (JAL link value; no delay slot).

Function
REQ-015 The block shall keep a fetch PC register; each issued request uses the PC and advances it by 4, modulo 2^32.
REQ-016 The block shall assert imem_req only when the count of buffered entries plus in-flight requests is less than DEPTH.
REQ-017 The response to a request issued in cycle N shall be written into the buffer at the end of cycle N+1, tagged with its pc.
REQ-018 The buffer shall be in-order FIFO; out_* shall present the head entry, and out_valid shall equal "buffer not empty".
REQ-019 The head entry shall pop when out_valid and out_ready are both 1; out_* shall stay stable while out_valid=1 and out_ready=0.
REQ-020 Same-cycle pop and response write shall be allowed when the buffer is full; occupancy shall then be unchanged.
REQ-021 Empty-buffer latency: the first word shall appear on out_* two cycles after its request (buffer write, then head visible); no bypass path.
REQ-022 On redirect=1 the block shall flush all buffered entries at the clock edge and discard any response returning in the next cycle (epoch bit toggled).
REQ-023 On redirect=1 the fetch PC shall load {redirect_pc[31:2],2'b00}; the next request shall go out in the following cycle.
REQ-024 If a pop and redirect happen in the same cycle, the pop shall complete (that instruction is consumed) and all remaining entries shall be flushed.
REQ-025 imem_req shall be 0 in the cycle redirect=1 is sampled.
REQ-026 Fetch state: RUN, or DRAIN (one cycle after redirect, dropping the stale response); DRAIN shall return to RUN unconditionally.

Reset
REQ-027 While rst_n=0: PC=RESET_PC, buffer empty, no in-flight request, state RUN, epoch 0.
REQ-028 While rst_n=0: imem_req=0, out_valid=0, out_instr/out_pc/out_pc4=0.
REQ-029 Reset assertion mid-operation shall discard all buffered and in-flight data immediately.
REQ-030 The first request shall occur in the first clk edge cycle after rst_n deasserts, at RESET_PC.

Structure
REQ-031 Package cpu_fetch_pkg shall hold: instruction width (32), default RESET_PC, PC increment (4), and the RUN/DRAIN state enum.
REQ-032 The buffer shall be a sub-module fetch_fifo (parameter DEPTH), holding {pc, instr} with push/pop/full/empty/flush ports.
REQ-033 Target size: 120-400 lines of RTL in total.

Verification
REQ-034 Reset release, out_ready=1, imem = word(addr/4): out_pc shall be 0,4,8,12 on consecutive cycles after 2-cycle latency; out_pc4 shall be 4,8,12,16.
REQ-035 out_ready=0 for 10 cycles: exactly DEPTH entries buffered, imem_req=0, out_* stable at pc 0; on release, no instruction is lost or duplicated.
REQ-036 redirect=1 with redirect_pc=12 while pcs 4,8 are buffered: next out_pc shall be 12; 4 and 8 shall never appear; the stale response shall be dropped.
REQ-037 redirect with redirect_pc=32'h0000_000B: imem_addr shall be 8.
REQ-038 Pop of pc 0 coincident with redirect to 8: pc 0 is counted as consumed; the next output is pc 8 (JAL case; link value out_pc4=4 observed at pop).
REQ-039 rst_n pulsed low for half a cycle mid-stream: out_valid shall drop at once; fetch shall restart at RESET_PC.
